// File: rtl/move_controller.sv
// rtl/move_controller.sv - sequences one player move: target calc, tile read, resolve, commit.
module move_controller #(
    parameter logic [3:0]  MAP_MAX     = 4'd10,
    parameter logic [15:0] INIT_FLOOR  = 16'd0,
    parameter logic [3:0]  INIT_X      = 4'd5,
    parameter logic [3:0]  INIT_Y      = 4'd10,
    parameter logic [15:0] INIT_HEALTH = 16'd100,
    parameter logic [31:0] INIT_KEYS   = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    output logic        move_done,
    output logic        move_blocked,
    output logic        map_rd_en,
    output logic        map_we,
    output logic [15:0] map_floor,
    output logic [3:0]  map_x,
    output logic [3:0]  map_y,
    output logic [15:0] map_wdata,
    input  logic [15:0] map_rdata,
    output logic [3:0]  res_pos_x,
    output logic [3:0]  res_pos_y,
    output logic [15:0] res_tile_id,
    input  logic [15:0] res_floor_out,
    input  logic [3:0]  res_goto_x,
    input  logic [3:0]  res_goto_y,
    input  logic [31:0] res_key_num,
    input  logic [15:0] res_health,
    input  logic [15:0] res_new_tile,
    output logic [15:0] floor,
    output logic [3:0]  player_x,
    output logic [3:0]  player_y,
    output logic [31:0] key_num,
    output logic [15:0] health
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_RESOLVE,
        S_COMMIT
    } state_t;

    state_t state, state_nxt;

    logic [3:0]  target_x, target_y;
    logic [15:0] tile_r;
    logic [15:0] r_floor;
    logic [3:0]  r_goto_x, r_goto_y;
    logic [31:0] r_keys;
    logic [15:0] r_health;
    logic [15:0] r_new_tile;
    logic        edge_blocked_r;

    logic [3:0]  step_x, step_y;
    logic        step_ok;
    logic        commit_blocked;

    // Candidate target cell; step_ok drops when the step would leave the map.
    always_comb begin
        step_x  = player_x;
        step_y  = player_y;
        step_ok = 1'b1;
        case (move_dir)
            2'd0: if (player_y == 4'd0)    step_ok = 1'b0; else step_y = player_y - 4'd1;
            2'd1: if (player_y >= MAP_MAX) step_ok = 1'b0; else step_y = player_y + 4'd1;
            2'd2: if (player_x == 4'd0)    step_ok = 1'b0; else step_x = player_x - 4'd1;
            default: if (player_x >= MAP_MAX) step_ok = 1'b0; else step_x = player_x + 4'd1;
        endcase
    end

    assign commit_blocked = (r_goto_x == player_x) && (r_goto_y == player_y) && (r_floor == floor);

    always_comb begin
        state_nxt  = state;
        move_ready = 1'b0;
        map_rd_en  = 1'b0;
        map_we     = 1'b0;
        case (state)
            S_IDLE: begin
                move_ready = 1'b1;
                if (move_valid && step_ok) state_nxt = S_READ;
            end
            S_READ: begin
                map_rd_en = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT:    state_nxt = S_RESOLVE;
            S_RESOLVE: state_nxt = S_COMMIT;
            S_COMMIT: begin
                map_we    = (r_new_tile != tile_r);
                state_nxt = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign move_done    = (state == S_COMMIT) || edge_blocked_r;
    assign move_blocked = (state == S_COMMIT) ? commit_blocked : edge_blocked_r;
    assign map_floor    = floor;
    assign map_x        = target_x;
    assign map_y        = target_y;
    assign map_wdata    = r_new_tile;
    assign res_pos_x    = target_x;
    assign res_pos_y    = target_y;
    assign res_tile_id  = tile_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            target_x       <= 4'd0;
            target_y       <= 4'd0;
            tile_r         <= 16'd0;
            r_floor        <= 16'd0;
            r_goto_x       <= 4'd0;
            r_goto_y       <= 4'd0;
            r_keys         <= 32'd0;
            r_health       <= 16'd0;
            r_new_tile     <= 16'd0;
            edge_blocked_r <= 1'b0;
            floor          <= INIT_FLOOR;
            player_x       <= INIT_X;
            player_y       <= INIT_Y;
            key_num        <= INIT_KEYS;
            health         <= INIT_HEALTH;
        end else begin
            state          <= state_nxt;
            edge_blocked_r <= (state == S_IDLE) && move_valid && !step_ok;
            if (state == S_IDLE && move_valid && step_ok) begin
                target_x <= step_x;
                target_y <= step_y;
            end
            if (state == S_WAIT) tile_r <= map_rdata;
            if (state == S_RESOLVE) begin
                r_floor    <= res_floor_out;
                r_goto_x   <= res_goto_x;
                r_goto_y   <= res_goto_y;
                r_keys     <= res_key_num;
                r_health   <= res_health;
                r_new_tile <= res_new_tile;
            end
            // Results are committed only as COMMIT closes, so a reset earlier leaves nothing behind.
            if (state == S_COMMIT) begin
                floor    <= r_floor;
                player_x <= r_goto_x;
                player_y <= r_goto_y;
                key_num  <= r_keys;
                health   <= r_health;
            end
        end
    end

endmodule

// File: tb/tb_move_controller.sv
// tb/tb_move_controller.sv - directed + random moves against a tile-map/resolver reference model.
module tb_move_controller;

    localparam logic [15:0] T_GROUND = 16'd0;
    localparam logic [15:0] T_WALL   = 16'd1;
    localparam logic [15:0] T_KEY0   = 16'd2;
    localparam logic [15:0] T_DOOR0  = 16'd6;
    localparam logic [15:0] T_TRAP   = 16'd10;
    localparam logic [15:0] T_STAIRS = 16'd11;

    typedef struct packed {
        logic [15:0] fl;
        logic [3:0]  gx;
        logic [3:0]  gy;
        logic [31:0] keys;
        logic [15:0] hp;
        logic [15:0] nt;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        move_valid = 1'b0;
    logic [1:0]  move_dir = 2'd0;
    logic        move_ready, move_done, move_blocked, map_rd_en, map_we;
    logic [15:0] map_floor, map_wdata;
    logic [15:0] map_rdata = 16'd0;
    logic [3:0]  map_x, map_y, res_pos_x, res_pos_y, player_x, player_y;
    logic [15:0] res_tile_id, floor, health;
    logic [31:0] key_num;
    res_t        rr;

    logic [15:0] mem     [4][11][11];
    logic [15:0] ref_map [4][11][11];
    logic [15:0] e_floor, e_health;
    logic [3:0]  e_x, e_y;
    logic [31:0] e_keys;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    move_controller dut (
        .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir),
        .move_ready(move_ready), .move_done(move_done), .move_blocked(move_blocked),
        .map_rd_en(map_rd_en), .map_we(map_we), .map_floor(map_floor),
        .map_x(map_x), .map_y(map_y), .map_wdata(map_wdata), .map_rdata(map_rdata),
        .res_pos_x(res_pos_x), .res_pos_y(res_pos_y), .res_tile_id(res_tile_id),
        .res_floor_out(rr.fl), .res_goto_x(rr.gx), .res_goto_y(rr.gy),
        .res_key_num(rr.keys), .res_health(rr.hp), .res_new_tile(rr.nt),
        .floor(floor), .player_x(player_x), .player_y(player_y),
        .key_num(key_num), .health(health)
    );

    // Game rules of the tile resolver: walls block, keys are collected, doors consume a key,
    // traps cost 10 health, stairs go up a floor in place.
    function automatic res_t rule(input logic [15:0] tile, input logic [15:0] fl,
                                  input logic [3:0] px, input logic [3:0] py,
                                  input logic [3:0] tx, input logic [3:0] ty,
                                  input logic [31:0] keys, input logic [15:0] hp);
        res_t r;
        int   k;
        r = '{fl: fl, gx: tx, gy: ty, keys: keys, hp: hp, nt: tile};
        if (tile == T_WALL) begin
            r.gx = px; r.gy = py;
        end else if (tile >= T_KEY0 && tile < T_KEY0 + 16'd4) begin
            k = int'(tile - T_KEY0);
            r.keys[8*k +: 8] = keys[8*k +: 8] + 8'd1;
            r.nt = T_GROUND;
        end else if (tile >= T_DOOR0 && tile < T_DOOR0 + 16'd4) begin
            k = int'(tile - T_DOOR0);
            if (keys[8*k +: 8] != 8'd0) begin
                r.keys[8*k +: 8] = keys[8*k +: 8] - 8'd1;
                r.nt = T_GROUND;
            end else begin
                r.gx = px; r.gy = py;
            end
        end else if (tile == T_TRAP) begin
            r.hp = hp - 16'd10;
        end else if (tile == T_STAIRS) begin
            r.fl = fl + 16'd1; r.gx = px; r.gy = py;
        end
        return r;
    endfunction

    always_comb rr = rule(res_tile_id, floor, player_x, player_y, res_pos_x, res_pos_y, key_num, health);

    always @(posedge clk) begin
        if (map_rd_en) map_rdata <= mem[map_floor[1:0]][map_y][map_x];
        if (map_we)    mem[map_floor[1:0]][map_y][map_x] <= map_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".floor"},  floor,    e_floor);
        chk({tag, ".x"},      player_x, e_x);
        chk({tag, ".y"},      player_y, e_y);
        chk({tag, ".keys"},   key_num,  e_keys);
        chk({tag, ".health"}, health,   e_health);
    endtask

    task automatic set_tile(input int f, input int x, input int y, input logic [15:0] t);
        mem[f][y][x] = t;
        ref_map[f][y][x] = t;
    endtask

    task automatic init_ref();
        e_floor = 16'd0; e_x = 4'd5; e_y = 4'd10; e_health = 16'd100; e_keys = 32'd0;
    endtask

    task automatic do_move(input logic [1:0] dir, input bit drop);
        int          n, tx, ty;
        bit          ok, exp_blk, exp_we;
        logic [15:0] tile;
        res_t        r;
        n = 0;
        while (!move_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_before_move", move_ready, 1'b1);
        tx = int'(e_x); ty = int'(e_y);
        case (dir)
            2'd0: ty--;
            2'd1: ty++;
            2'd2: tx--;
            default: tx++;
        endcase
        ok = (tx >= 0 && tx <= 10 && ty >= 0 && ty <= 10);
        move_valid = 1'b1; move_dir = dir;
        @(negedge clk);
        move_valid = 1'b0;
        if (!ok) begin
            chk("edge.done", move_done, 1'b1);
            chk("edge.blocked", move_blocked, 1'b1);
            chk("edge.rd_en", map_rd_en, 1'b0);
            chk("edge.ready", move_ready, 1'b1);
            @(negedge clk);
            chk("edge.done_pulse", move_done, 1'b0);
            chk_state("edge");
            return;
        end
        tile = ref_map[e_floor[1:0]][ty][tx];
        r = rule(tile, e_floor, e_x, e_y, 4'(tx), 4'(ty), e_keys, e_health);
        exp_blk = (r.gx == e_x) && (r.gy == e_y) && (r.fl == e_floor);
        exp_we  = (r.nt != tile);
        chk("read.rd_en", map_rd_en, 1'b1);
        chk("read.ready", move_ready, 1'b0);
        chk("read.addr", {map_floor, map_x, map_y}, {e_floor, 4'(tx), 4'(ty)});
        chk("read.done", move_done, 1'b0);
        if (drop) begin move_valid = 1'b1; move_dir = ~dir; end
        @(negedge clk);
        chk("wait.rd_en", map_rd_en, 1'b0);
        @(negedge clk);
        chk("resolve.we_done", {map_we, move_done}, 2'b00);
        @(negedge clk);
        move_valid = 1'b0;
        chk("commit.done", move_done, 1'b1);
        chk("commit.blocked", move_blocked, exp_blk);
        chk("commit.we", map_we, exp_we);
        if (exp_we) chk("commit.wdata", {map_wdata, map_floor, map_x, map_y},
                        {r.nt, e_floor, 4'(tx), 4'(ty)});
        ref_map[e_floor[1:0]][ty][tx] = r.nt;
        e_floor = r.fl; e_x = r.gx; e_y = r.gy; e_keys = r.keys; e_health = r.hp;
        @(negedge clk);
        chk("after.ready_done", {move_ready, move_done}, 2'b10);
        chk_state("after");
        if (drop) begin
            @(negedge clk);
            chk("drop.rd_en_done", {map_rd_en, move_done}, 2'b00);
        end
    endtask

    initial begin
        int bad, v;
        for (int f = 0; f < 4; f++)
            for (int y = 0; y < 11; y++)
                for (int x = 0; x < 11; x++) set_tile(f, x, y, T_GROUND);
        init_ref();
        repeat (2) @(negedge clk);
        chk("reset.strobes", {move_ready, move_done, map_rd_en, map_we}, 4'b1000);
        chk_state("reset");
        rst = 1'b0;
        @(negedge clk);

        do_move(2'd1, 1'b0);                      // y=MAP_MAX going down
        do_move(2'd0, 1'b0);                      // ground at (5,9)
        set_tile(0, 5, 8, T_KEY0 + 16'd1);
        do_move(2'd0, 1'b0);                      // key_1 pickup
        set_tile(0, 5, 7, T_DOOR0);
        do_move(2'd0, 1'b0);                      // locked door
        set_tile(0, 4, 8, T_KEY0);
        do_move(2'd2, 1'b0);
        do_move(2'd3, 1'b0);
        do_move(2'd0, 1'b1);                      // door opens, with dropped request
        set_tile(0, 4, 7, T_WALL);
        do_move(2'd2, 1'b0);                      // wall
        set_tile(0, 5, 6, T_STAIRS);
        do_move(2'd0, 1'b0);                      // stairs: same cell, new floor
        set_tile(1, 4, 6, T_TRAP);
        for (int i = 0; i < 5; i++) do_move(2'd2, 1'b0);
        do_move(2'd2, 1'b0);                      // x=0 going left
        do_move(2'd2, 1'b0);

        // Reset during RESOLVE of a key move must leave map and state untouched.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        init_ref();
        set_tile(0, 5, 9, T_KEY0 + 16'd2);
        @(negedge clk);
        move_valid = 1'b1; move_dir = 2'd0;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.strobes", {move_ready, move_done, map_we}, 3'b100);
        chk_state("rst_mid");
        @(negedge clk);
        chk("rst_mid.no_done", {move_done, map_we}, 2'b00);
        chk("rst_mid.tile", mem[0][9][5], T_KEY0 + 16'd2);

        for (int f = 0; f < 4; f++)
            for (int y = 0; y < 11; y++)
                for (int x = 0; x < 11; x++) begin
                    v = int'($urandom_range(0, 19));
                    if (v < 9)       set_tile(f, x, y, T_GROUND);
                    else if (v < 11) set_tile(f, x, y, T_WALL);
                    else if (v < 14) set_tile(f, x, y, T_KEY0 + 16'($urandom_range(0, 3)));
                    else if (v < 17) set_tile(f, x, y, T_DOOR0 + 16'($urandom_range(0, 3)));
                    else if (v < 19) set_tile(f, x, y, T_TRAP);
                    else             set_tile(f, x, y, T_STAIRS);
                end
        for (int i = 0; i < 150; i++) do_move(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));

        repeat (2) @(negedge clk);
        bad = 0;
        for (int f = 0; f < 4; f++)
            for (int y = 0; y < 11; y++)
                for (int x = 0; x < 11; x++)
                    if (mem[f][y][x] !== ref_map[f][y][x]) bad++;
        chk("final.map_diffs", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
